// File: rtl/monster_sprite_engine.sv
// monster_sprite_engine: sprite hit-test, ROM addressing, 2-stage pixel pipe and invader-style motion
module monster_sprite_engine #(
    parameter int         SPR_W       = 26,
    parameter int         SPR_H       = 37,
    parameter int         START_X     = 16,
    parameter int         START_Y     = 32,
    parameter int         SPEED       = 2,
    parameter int         DROP        = 8,
    parameter int         SCREEN_W    = 640,
    parameter int         FLOOR_Y     = 400,
    parameter logic [7:0] TRANSPARENT = 8'h00
) (
    input  logic       i_clk2,
    input  logic       i_rst_n,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic       i_active,
    input  logic       i_frame_tick,
    input  logic       i_enable,
    input  logic       i_restart,
    input  logic [7:0] i_rom_data,
    output logic [9:0] o_rom_addr,
    output logic [7:0] o_pixel,
    output logic       o_hit,
    output logic [9:0] o_pos_x,
    output logic [9:0] o_pos_y,
    output logic       o_landed
);
    typedef enum logic [2:0] {MOVE_R, MOVE_L, STEP_L, STEP_R, LANDED} state_t;

    state_t     state_q, state_d;
    logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [9:0] rel_x, rel_y, step_y;
    logic       in_box, in_box_q;
    logic [7:0] pixel_q;
    logic       hit_q;

    // Hit test against the sprite box and ROM address (row * pitch + col), zero outside the box
    always_comb begin
        rel_x      = i_x - pos_x_q;
        rel_y      = i_y - pos_y_q;
        in_box     = i_active
                   && i_x >= pos_x_q && i_x <= pos_x_q + 10'(SPR_W - 1)
                   && i_y >= pos_y_q && i_y <= pos_y_q + 10'(SPR_H - 1);
        o_rom_addr = in_box ? rel_y * 10'(SPR_W) + rel_x : '0;
    end

    // Motion next-state: restart dominates, otherwise advance only on enabled frame ticks
    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        step_y  = pos_y_q + 10'(DROP);
        if (i_restart) begin
            state_d = MOVE_R;
            pos_x_d = 10'(START_X);
            pos_y_d = 10'(START_Y);
        end else if (i_frame_tick && i_enable) begin
            case (state_q)
                MOVE_R: if (pos_x_q + 10'(SPEED + SPR_W) > 10'(SCREEN_W)) state_d = STEP_L;
                        else pos_x_d = pos_x_q + 10'(SPEED);
                MOVE_L: if (pos_x_q < 10'(SPEED)) state_d = STEP_R;
                        else pos_x_d = pos_x_q - 10'(SPEED);
                STEP_L: begin
                    pos_y_d = step_y;
                    state_d = (step_y + 10'(SPR_H) >= 10'(FLOOR_Y)) ? LANDED : MOVE_L;
                end
                STEP_R: begin
                    pos_y_d = step_y;
                    state_d = (step_y + 10'(SPR_H) >= 10'(FLOOR_Y)) ? LANDED : MOVE_R;
                end
                default: ;
            endcase
        end
    end

    // Motion state and position registers
    always_ff @(posedge i_clk2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= MOVE_R;
            pos_x_q <= 10'(START_X);
            pos_y_q <= 10'(START_Y);
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
        end
    end

    // Pixel pipe: stage 1 aligns in_box with ROM output, stage 2 applies colour key
    always_ff @(posedge i_clk2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_box_q <= 1'b0;
            pixel_q  <= '0;
            hit_q    <= 1'b0;
        end else begin
            in_box_q <= in_box;
            pixel_q  <= in_box_q ? i_rom_data : '0;
            hit_q    <= in_box_q && (i_rom_data != TRANSPARENT);
        end
    end

    assign o_pixel  = pixel_q;
    assign o_hit    = hit_q;
    assign o_pos_x  = pos_x_q;
    assign o_pos_y  = pos_y_q;
    assign o_landed = (state_q == LANDED);
endmodule

// File: tb/tb_monster_sprite_engine.sv
// tb_monster_sprite_engine: randomized self-checking bench with a behavioural sprite model
module tb_monster_sprite_engine;
    logic       clk2 = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] x = '0, y = '0;
    logic       active = 1'b0, tick = 1'b0, en = 1'b0, restart = 1'b0;
    logic [7:0] rom_data = '0;
    logic [9:0] rom_addr;
    logic [7:0] pixel;
    logic       hit;
    logic [9:0] pos_x, pos_y;
    logic       landed;

    logic [7:0] rom [0:1023];
    int n_chk = 0, n_pass = 0;
    int mx, my, dir;
    bit pend, land;

    typedef struct {logic [7:0] pix; logic hit;} exp_t;
    exp_t q[$];

    monster_sprite_engine dut (
        .i_clk2(clk2), .i_rst_n(rst_n), .i_x(x), .i_y(y), .i_active(active),
        .i_frame_tick(tick), .i_enable(en), .i_restart(restart), .i_rom_data(rom_data),
        .o_rom_addr(rom_addr), .o_pixel(pixel), .o_hit(hit),
        .o_pos_x(pos_x), .o_pos_y(pos_y), .o_landed(landed)
    );

    always #20 clk2 = ~clk2;

    always @(posedge clk2) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        mx = 16; my = 32; dir = 1; pend = 0; land = 0;
    endtask

    // One frame tick of march motion: bounce costs a whole tick spent dropping
    task automatic model_tick();
        if (land) return;
        if (pend) begin
            my += 8;
            pend = 0;
            dir = -dir;
            land = (my + 37 >= 400);
        end else if (dir > 0 ? (mx + 2 + 26 > 640) : (mx < 2)) pend = 1;
        else mx += 2 * dir;
    endtask

    task automatic drive(input logic [9:0] nx, ny, input logic na, nt, ne, nr);
        int ix, iy, a;
        bit ib;
        x = nx; y = ny; active = na; tick = nt; en = ne; restart = nr;
        #1;
        ix = int'(nx); iy = int'(ny);
        ib = na && ix >= mx && ix < mx + 26 && iy >= my && iy < my + 37;
        a = ib ? (iy - my) * 26 + (ix - mx) : 0;
        check("rom_addr", 32'(rom_addr), 32'(a));
        q.push_back('{ib ? rom[a] : 8'h00, ib && rom[a] != 8'h00});
    endtask

    task automatic edge_check();
        exp_t e;
        @(posedge clk2);
        if (restart) model_reset();
        else if (tick && en) model_tick();
        #1;
        check("pos_x", 32'(pos_x), 32'(mx));
        check("pos_y", 32'(pos_y), 32'(my));
        check("landed", 32'(landed), 32'(land));
        if (q.size() == 2) begin
            e = q.pop_front();
            check("pixel", 32'(pixel), 32'(e.pix));
            check("hit", 32'(hit), 32'(e.hit));
        end
    endtask

    task automatic rand_cycle(input logic nt, ne);
        edge_check();
        drive(10'(mx - 3 + int'($urandom_range(0, 31))), 10'(my - 3 + int'($urandom_range(0, 42))),
              $urandom_range(0, 7) != 0, nt, ne, 1'b0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 1024; i += 7) rom[i] = 8'h00;
        rom[0] = 8'h5A; rom[961] = 8'hC3; rom[5] = 8'h00;
        model_reset();
        #50;
        check("rst_pos_x", 32'(pos_x), 32'd16);
        check("rst_pos_y", 32'(pos_y), 32'd32);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_landed", 32'(landed), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        @(negedge clk2) rst_n = 1'b1;
        drive(10'd16, 10'd32, 1, 0, 0, 0);
        check("corner_tl", 32'(rom_addr), 32'd0);
        edge_check(); drive(10'd41, 10'd68, 1, 0, 0, 0);
        check("corner_br", 32'(rom_addr), 32'd961);
        edge_check(); drive(10'd15, 10'd32, 1, 0, 0, 0);
        edge_check(); drive(10'd42, 10'd32, 1, 0, 0, 0);
        edge_check(); drive(10'd16, 10'd69, 1, 0, 0, 0);
        edge_check(); drive(10'd21, 10'd32, 1, 0, 0, 0);
        edge_check(); drive(10'd16, 10'd32, 0, 0, 0, 0);
        edge_check(); drive(10'd0, 10'd0, 0, 0, 0, 0);
        edge_check(); drive(10'd0, 10'd0, 0, 0, 0, 0);
        edge_check(); drive(10'd0, 10'd0, 0, 0, 0, 0);
        cyc = 0;
        while (!land && cyc < 40000) begin
            rand_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0);
            cyc++;
        end
        if (!land) check("landing_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 20; i++) rand_cycle(1, 1);
        check("landed_hold", 32'(landed), 32'd1);
        edge_check(); drive(10'd0, 10'd0, 0, 1, 1, 1);
        edge_check();
        check("restart_x", 32'(pos_x), 32'd16);
        check("restart_y", 32'(pos_y), 32'd32);
        check("restart_landed", 32'(landed), 32'd0);
        drive(10'd20, 10'd40, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) rand_cycle(1, 0);
        check("disabled_x", 32'(pos_x), 32'd16);
        for (int i = 0; i < 30; i++) rand_cycle(1, 1);
        edge_check();
        #4 rst_n = 1'b0;
        #1;
        q.delete();
        model_reset();
        check("midrst_x", 32'(pos_x), 32'd16);
        check("midrst_y", 32'(pos_y), 32'd32);
        check("midrst_hit", 32'(hit), 32'd0);
        check("midrst_pixel", 32'(pixel), 32'd0);
        @(negedge clk2) rst_n = 1'b1;
        drive(10'd16, 10'd32, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) rand_cycle($urandom_range(0, 1) != 0, 1);
        edge_check();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
